// File: rtl/adder_pkg.sv
// Shared types and parameter checks for the digit-serial adder.
// Pure declarations: no latency, no backpressure.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // A legal geometry splits the operand into a whole number of digits.
    function automatic bit width_legal(int width, int digit);
        return (digit >= 1) && (width > 0) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder slice; also reports the carry into its MSB.
// Purely combinational: zero latency, no backpressure.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_msb
);

    always_comb begin
        logic cy;
        cy    = ci;
        c_msb = ci;
        sum   = '0;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb  = cy;
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        co = cy;
    end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract of two WIDTH-bit operands, DIGIT bits per cycle.
// Latency: WIDTH/DIGIT cycles in BUSY; result held in DONE until out_ready.
// Backpressure: in_ready low while busy or holding a result; one op in flight.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int STEPS = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (!width_legal(WIDTH, DIGIT)) begin : g_bad_geometry
            $error("serial_adder: WIDTH must be a positive multiple of DIGIT >= 1");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  a_q, b_q, res_q;
    logic              carry_q;
    logic              in_ready_q, out_valid_q;
    logic [WIDTH-1:0]  out_sum_q;
    logic              out_carry_q, out_ovf_q;

    logic [DIGIT-1:0]       dsum;
    logic                   dco, dmsb;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
    logic                   last_step, handshake;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .sum   (dsum),
        .co    (dco),
        .c_msb (dmsb)
    );

    // New digit enters at the MSB end, so after STEPS shifts bit 0 lands at bit 0.
    assign res_cat   = {dsum, res_q};
    assign res_next  = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign last_step = (cnt_q == CW'(STEPS - 1));
    assign handshake = in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == IDLE);
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | carry_in;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    res_q   <= res_next;
                    carry_q <= dco;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_step) begin
                        out_sum_q   <= res_next;
                        out_carry_q <= dco;
                        out_ovf_q   <= dco ^ dmsb;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_carry    = out_carry_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three digit widths (2, 1, 8) on WIDTH=8, arithmetic
// model with per-cycle compare plus directed literal expectations.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       carry_in, sub;
    logic       in_valid_v   [3];
    logic       in_ready_v   [3];
    logic       out_valid_v  [3];
    logic       out_ready_v  [3];
    logic [7:0] out_sum_v    [3];
    logic       out_carry_v  [3];
    logic       out_ovf_v    [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic       pending  [3];
    logic       seen_vld [3];
    logic [9:0] exp_res  [3];
    int         hs_cyc   [3];
    int         exp_lat  [3];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_sum(out_sum_v[0]),
        .out_carry(out_carry_v[0]), .out_overflow(out_ovf_v[0]));

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_sum(out_sum_v[1]),
        .out_carry(out_carry_v[1]), .out_overflow(out_ovf_v[1]));

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_sum(out_sum_v[2]),
        .out_carry(out_carry_v[2]), .out_overflow(out_ovf_v[2]));

    // Returns {overflow, carry, sum} from plain integer arithmetic.
    function automatic logic [9:0] model(logic [7:0] ma, logic [7:0] mb, logic mci, logic ms);
        int ua, ub, sa, sb, ici, ur, sr;
        logic c, o;
        ua  = int'(ma);
        ub  = int'(mb);
        sa  = int'($signed(ma));
        sb  = int'($signed(mb));
        ici = mci ? 1 : 0;
        if (ms) begin
            ur = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub + ici;
            c  = (ur > 255);
            sr = sa + sb + ici;
        end
        o = (sr > 127) || (sr < -128);
        return {o, c, ur[7:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Records each accepted operation and its expected result.
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                pending[k] = 1'b0;
            end else begin
                if (out_valid_v[k] && out_ready_v[k]) pending[k] = 1'b0;
                if (in_valid_v[k] && in_ready_v[k]) begin
                    pending[k] = 1'b1;
                    exp_res[k] = model(a, b, carry_in, sub);
                    hs_cyc[k]  = cyc;
                end
            end
        end
    end

    // Latency is counted in edges from the handshake edge to the edge at
    // which a consumer first samples out_valid high.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && out_valid_v[k]) begin
                checks++;
                if (!pending[k]) begin
                    errors++;
                    $display("FAIL stale_valid[%0d]: out_valid=1 with no accepted operation", k);
                end else if ({out_ovf_v[k], out_carry_v[k], out_sum_v[k]} !== exp_res[k]) begin
                    errors++;
                    $display("FAIL model[%0d]: got ovf/carry/sum %0h expected %0h", k,
                             {out_ovf_v[k], out_carry_v[k], out_sum_v[k]}, exp_res[k]);
                end
                if (!seen_vld[k] && pending[k])
                    chk($sformatf("latency[%0d]", k), 32'(cyc - hs_cyc[k] + 1), 32'(exp_lat[k]));
                seen_vld[k] = 1'b1;
            end else begin
                seen_vld[k] = 1'b0;
            end
        end
    end

    task automatic run_op(int k, logic [7:0] ta, logic [7:0] tb2, logic tci, logic ts,
                          logic [7:0] esum, logic ec, logic eo, int hold);
        int n;
        n = 0;
        while (!in_ready_v[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_op", 32'(in_ready_v[k]), 32'd1);
        a = ta; b = tb2; carry_in = tci; sub = ts;
        in_valid_v[k] = 1'b1;
        @(negedge clk);
        in_valid_v[k] = 1'b0;
        a = 8'hA5; b = 8'h5A; carry_in = 1'b1; sub = 1'b0;
        n = 0;
        while (!out_valid_v[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", 32'(out_valid_v[k]), 32'd1);
        chk("sum", 32'(out_sum_v[k]), 32'(esum));
        chk("carry", 32'(out_carry_v[k]), 32'(ec));
        chk("overflow", 32'(out_ovf_v[k]), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready_v[k]), 32'd0);
            chk("hold_valid", 32'(out_valid_v[k]), 32'd1);
            chk("hold_sum", 32'(out_sum_v[k]), 32'(esum));
            chk("hold_flags", 32'({out_carry_v[k], out_ovf_v[k]}), 32'({ec, eo}));
        end
        out_ready_v[k] = 1'b1;
        @(negedge clk);
        out_ready_v[k] = 1'b0;
        chk("in_ready_after_release", 32'(in_ready_v[k]), 32'd1);
        chk("valid_drop", 32'(out_valid_v[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_lat[0] = 5; exp_lat[1] = 9; exp_lat[2] = 2;
        for (int k = 0; k < 3; k++) begin
            in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
            pending[k] = 1'b0; seen_vld[k] = 1'b0; exp_res[k] = '0; hs_cyc[k] = 0;
        end
        a = 8'h00; b = 8'h00; carry_in = 1'b0; sub = 1'b0;
        rst_n = 1'b0;

        // Reset values before any clock edge.
        #3;
        for (int k = 0; k < 3; k++) begin
            chk("reset_in_ready", 32'(in_ready_v[k]), 32'd0);
            chk("reset_outputs", 32'({out_valid_v[k], out_carry_v[k], out_ovf_v[k], out_sum_v[k]}), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_first_edge", 32'(in_ready_v[0]), 32'd0);
        @(negedge clk);
        chk("in_ready_first_edge", 32'(in_ready_v[0]), 32'd1);

        // DIGIT=2
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 3);
        run_op(0, 8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0, 1);
        run_op(0, 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0);

        // Reset while the second digit is being added.
        a = 8'h55; b = 8'h55; carry_in = 1'b0; sub = 1'b0;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midbusy_rst_in_ready", 32'(in_ready_v[0]), 32'd0);
        chk("midbusy_rst_outputs", 32'({out_valid_v[0], out_carry_v[0], out_ovf_v[0], out_sum_v[0]}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_stale_valid", 32'(out_valid_v[0]), 32'd0);
        end
        run_op(0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 0);

        // DIGIT=1 and DIGIT=8
        run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 2);
        run_op(2, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op(2, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-002 SHALL have parameter DIGIT, default 1, bits added per clock cycle.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands present on a, b, carry_in and sub.
REQ-006 SHALL have port in_ready, output, 1, block can accept a new operation.
REQ-007 SHALL have port a, input, WIDTH, first operand.
REQ-008 SHALL have port b, input, WIDTH, second operand.
REQ-009 SHALL have port carry_in, input, 1, carry into bit 0; ignored when sub=1.
REQ-010 SHALL have port sub, input, 1, mode select: 0 = a+b+carry_in, 1 = a-b.
REQ-011 SHALL have port out_valid, output, 1, result ports hold a completed result.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port out_sum, output, WIDTH, result.
REQ-014 SHALL have port out_carry, output, 1, carry out of the MSB; for sub=1, 1 means no borrow.
REQ-015 SHALL have port out_overflow, output, 1, two's-complement signed overflow.

Function
REQ-016 SHALL reject at elaboration any WIDTH not a positive multiple of DIGIT, or DIGIT < 1.
REQ-017 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-018 SHALL assert in_ready only in IDLE; handshake occurs when in_valid and in_ready are both high.
REQ-019 On handshake, SHALL latch a, the effective b (b, or ~b when sub=1), and the initial carry (carry_in, or 1 when sub=1), clear the digit counter, and enter BUSY.
REQ-020 In each BUSY cycle, SHALL add the low DIGIT bits of both operand shift registers plus the carry register, shift the DIGIT sum bits into the result register from the MSB end, shift the operands right by DIGIT, and update the carry register.
REQ-021 SHALL spend exactly WIDTH/DIGIT cycles in BUSY, then enter DONE; out_valid rises WIDTH/DIGIT+1 cycles after the handshake edge.
REQ-022 SHALL compute out_overflow as the carry into the MSB XOR the carry out of the MSB, captured during the final BUSY cycle.
REQ-023 SHALL hold out_valid and all result ports stable in DONE while out_ready is low.
REQ-024 In DONE with out_ready high, SHALL return to IDLE on the next edge; in_ready rises that edge.
REQ-025 SHALL ignore in_valid while in BUSY or DONE and SHALL ignore out_ready outside DONE.
REQ-026 SHALL leave out_sum, out_carry and out_overflow at their last values outside DONE; only out_valid qualifies them.

Reset
REQ-027 While rst_n is low, regardless of clk, SHALL force state IDLE, counter 0, carry register 0, and out_sum 0, out_carry 0, out_overflow 0, out_valid 0, in_ready 0.
REQ-028 After rst_n deasserts, in_ready SHALL be 1 from the first edge onward; reset during BUSY or DONE discards the operation with no partial result emitted.

Structure
REQ-029 SHALL place the FSM state enumeration and the WIDTH/DIGIT legality check in shared package adder_pkg.
REQ-030 SHALL instantiate one combinational sub-module, digit_adder (DIGIT-bit ripple of full adders, carry in/out plus carry into the MSB); the FSM, counter and shift registers live in serial_adder.

Verification (WIDTH=8, DIGIT=2 unless stated)
REQ-031 Bench SHALL check a=0xFF, b=0x01, carry_in=0, sub=0 -> out_sum=0x00, out_carry=1, out_overflow=0, out_valid 5 cycles after the handshake.
REQ-032 Bench SHALL check a=0x7F, b=0x01, sub=0 -> out_sum=0x80, out_carry=0, out_overflow=1.
REQ-033 Bench SHALL check a=0x05, b=0x07, sub=1 -> out_sum=0xFE, out_carry=0, out_overflow=0; and a=0x80, b=0x01, sub=1 -> 0x7F, out_overflow=1.
REQ-034 Bench SHALL hold out_ready low 3 cycles in DONE -> outputs unchanged and in_ready=0 throughout; release -> in_ready=1 on the next edge.
REQ-035 Bench SHALL assert rst_n low mid-BUSY (2nd digit) -> outputs zero immediately; after release, a new 0x10+0x20 yields 0x30 with no stale out_valid.
REQ-036 Bench SHALL repeat REQ-031 with DIGIT=1 and DIGIT=8 -> identical results with latency 9 and 2 cycles.
